// File: rtl/mest_pro_pkg.sv
// Shared MEST-Pro constants: board channel counts and debounce/hold timing
// for hardware and for simulation.
package mest_pro_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int HOLD_CYCLES_DEFAULT     = 100000000;

  localparam int DEBOUNCE_CYCLES_SIM = 4;
  localparam int HOLD_CYCLES_SIM     = 16;

  localparam int N_BTN_BOARD = 4;
  localparam int N_SW_BOARD  = 4;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchronizer, stability-count debounce, registered
// level and edge pulses, plus an optional one-shot long-press detector.
module debounce_channel
  import mest_pro_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT,
  parameter bit HOLD_EN         = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic change,
  output logic hold
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES);

  logic          s1_p0;
  logic          s2_p1;
  logic [CW-1:0] cnt;
  logic          level_q;
  logic          rise_q;
  logic          fall_q;
  logic          change_q;
  logic          accept;

  assign accept = (s2_p1 != level_q) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  // Stage boundary: synchronizer -> stability counter -> level and pulses
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_p0    <= 1'b0;
      s2_p1    <= 1'b0;
      cnt      <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      change_q <= 1'b0;
    end else begin
      s1_p0    <= raw;
      s2_p1    <= s1_p0;
      rise_q   <= accept && s2_p1;
      fall_q   <= accept && !s2_p1;
      change_q <= accept;
      if (s2_p1 == level_q) begin
        cnt <= '0;
      end else if (accept) begin
        cnt     <= '0;
        level_q <= s2_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level  = level_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign change = change_q;

  generate
    if (HOLD_EN) begin : g_hold
      logic [HW-1:0] hcnt;
      logic          hold_q;

      // Saturating count of pressed cycles; the pulse fires only on the
      // transition into saturation, so a long hold never repeats.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          hcnt   <= '0;
          hold_q <= 1'b0;
        end else begin
          hold_q <= level_q && (hcnt == HW'(HOLD_CYCLES - 2));
          if (!level_q) begin
            hcnt <= '0;
          end else if (hcnt != HW'(HOLD_CYCLES - 1)) begin
            hcnt <= hcnt + 1'b1;
          end
        end
      end

      assign hold = hold_q;
    end else begin : g_no_hold
      assign hold = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/board_input_conditioner.sv
// Debounces the raw board buttons and switches into clean levels and
// single-cycle event pulses for the rest of the MEST-Pro design.
module board_input_conditioner
  import mest_pro_pkg::*;
#(
  parameter int N_BTN           = N_BTN_BOARD,
  parameter int N_SW            = N_SW_BOARD,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT
) (
  input  logic             CLK100MHZ,
  input  logic             RSTN,
  input  logic [N_BTN-1:0] BTN,
  input  logic [N_SW-1:0]  SW,
  output logic [N_BTN-1:0] BTN_LEVEL,
  output logic [N_BTN-1:0] BTN_PRESS,
  output logic [N_BTN-1:0] BTN_RELEASE,
  output logic [N_BTN-1:0] BTN_HOLD,
  output logic [N_SW-1:0]  SW_LEVEL,
  output logic [N_SW-1:0]  SW_CHANGE
);

  logic [N_BTN-1:0] btn_change_unused;
  logic [N_SW-1:0]  sw_rise_unused;
  logic [N_SW-1:0]  sw_fall_unused;
  logic [N_SW-1:0]  sw_hold_unused;

  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .HOLD_EN        (1'b1)
      ) u_chan (
        .clk   (CLK100MHZ),
        .rstn  (RSTN),
        .raw   (BTN[i]),
        .level (BTN_LEVEL[i]),
        .rise  (BTN_PRESS[i]),
        .fall  (BTN_RELEASE[i]),
        .change(btn_change_unused[i]),
        .hold  (BTN_HOLD[i])
      );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .HOLD_EN        (1'b0)
      ) u_chan (
        .clk   (CLK100MHZ),
        .rstn  (RSTN),
        .raw   (SW[i]),
        .level (SW_LEVEL[i]),
        .rise  (sw_rise_unused[i]),
        .fall  (sw_fall_unused[i]),
        .change(SW_CHANGE[i]),
        .hold  (sw_hold_unused[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_board_input_conditioner.sv
// Bench for board_input_conditioner at simulation timing (debounce 4, hold 16):
// hand vector table, directed corner sequences and a random run against a model.
module tb_board_input_conditioner;
  import mest_pro_pkg::*;

  localparam int D  = DEBOUNCE_CYCLES_SIM;
  localparam int H  = HOLD_CYCLES_SIM;
  localparam int NC = 8;

  logic       clk = 1'b0;
  logic       RSTN;
  logic [3:0] BTN, SW;
  logic [3:0] BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_HOLD, SW_LEVEL, SW_CHANGE;

  always #5 clk = ~clk;

  board_input_conditioner #(
    .N_BTN(4), .N_SW(4), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)
  ) dut (
    .CLK100MHZ  (clk),
    .RSTN       (RSTN),
    .BTN        (BTN),
    .SW         (SW),
    .BTN_LEVEL  (BTN_LEVEL),
    .BTN_PRESS  (BTN_PRESS),
    .BTN_RELEASE(BTN_RELEASE),
    .BTN_HOLD   (BTN_HOLD),
    .SW_LEVEL   (SW_LEVEL),
    .SW_CHANGE  (SW_CHANGE)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: a channel accepts the opposite level once the last D
  // synchronized samples (raw samples two edges old) all disagree with it.
  bit hist [NC][D+1];
  bit m_lvl[NC], m_rise[NC], m_fall[NC], m_hold[NC];
  int on_cnt[NC];

  function automatic bit raw_of(int ch);
    return (ch < 4) ? BTN[ch] : SW[ch-4];
  endfunction

  task automatic model_edge();
    bit acc;
    for (int ch = 0; ch < NC; ch++) begin
      if (!RSTN) begin
        for (int j = 0; j <= D; j++) hist[ch][j] = 1'b0;
        m_lvl[ch] = 0; m_rise[ch] = 0; m_fall[ch] = 0; m_hold[ch] = 0; on_cnt[ch] = 0;
      end else begin
        if (m_lvl[ch]) on_cnt[ch]++;
        else on_cnt[ch] = 0;
        m_hold[ch] = (ch < 4) && (on_cnt[ch] == H - 1);
        acc = 1'b1;
        for (int k = 0; k < D; k++) if (hist[ch][1+k] == m_lvl[ch]) acc = 1'b0;
        m_rise[ch] = acc && !m_lvl[ch];
        m_fall[ch] = acc && m_lvl[ch];
        if (acc) m_lvl[ch] = !m_lvl[ch];
        for (int j = D; j >= 1; j--) hist[ch][j] = hist[ch][j-1];
        hist[ch][0] = raw_of(ch);
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] b, input logic [3:0] s);
    logic [3:0] el, ep, er, eh, sl, sc;
    RSTN = r; BTN = b; SW = s;
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 4; i++) begin
      el[i] = m_lvl[i]; ep[i] = m_rise[i]; er[i] = m_fall[i]; eh[i] = m_hold[i];
      sl[i] = m_lvl[i+4]; sc[i] = m_rise[i+4] | m_fall[i+4];
    end
    chk("m_btn_level", BTN_LEVEL, el);
    chk("m_btn_press", BTN_PRESS, ep);
    chk("m_btn_release", BTN_RELEASE, er);
    chk("m_btn_hold", BTN_HOLD, eh);
    chk("m_sw_level", SW_LEVEL, sl);
    chk("m_sw_change", SW_CHANGE, sc);
  endtask

  typedef struct {
    logic       rstn;
    logic [3:0] btn, sw, lvl, prs, rel, hld;
  } vec_t;
  vec_t vq[$];

  task automatic addv(input logic r, input logic [3:0] b, input logic [3:0] l,
                      input logic [3:0] p, input logic [3:0] rl);
    vec_t v;
    v.rstn = r; v.btn = b; v.sw = 4'h0; v.lvl = l; v.prs = p; v.rel = rl; v.hld = 4'h0;
    vq.push_back(v);
  endtask

  initial begin
    int pstep, hstep, rstep, hcount, pcount, rises;
    logic [3:0] acc;
    logic prev;
    int rate;
    logic [3:0] rb, rs;

    RSTN = 1'b0; BTN = '0; SW = '0;

    // Vector table: reset state, clean press/release, reset aborting a count.
    addv(0, 4'h0, 4'h0, 4'h0, 4'h0);
    addv(0, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 8; k++) addv(1, 4'h1, (k >= 5) ? 4'h1 : 4'h0, (k == 5) ? 4'h1 : 4'h0, 4'h0);
    for (int k = 0; k < 6; k++) addv(1, 4'h0, (k < 5) ? 4'h1 : 4'h0, 4'h0, (k == 5) ? 4'h1 : 4'h0);
    for (int k = 0; k < 3; k++) addv(1, 4'h1, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 2; k++) addv(0, 4'h1, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 7; k++) addv(1, 4'h1, (k >= 5) ? 4'h1 : 4'h0, (k == 5) ? 4'h1 : 4'h0, 4'h0);
    for (int k = 0; k < 6; k++) addv(1, 4'h0, (k < 5) ? 4'h1 : 4'h0, 4'h0, (k == 5) ? 4'h1 : 4'h0);

    foreach (vq[i]) begin
      step(vq[i].rstn, vq[i].btn, vq[i].sw);
      chk("tbl_btn_level", BTN_LEVEL, vq[i].lvl);
      chk("tbl_btn_press", BTN_PRESS, vq[i].prs);
      chk("tbl_btn_release", BTN_RELEASE, vq[i].rel);
      chk("tbl_btn_hold", BTN_HOLD, vq[i].hld);
      chk("tbl_sw_quiet", {SW_LEVEL, SW_CHANGE}, 8'h00);
    end

    // Bounce on BTN[1]: one press, 5 edges after the last transition is sampled.
    pstep = -1; pcount = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 22; i++) begin
      if (i < 4) rb = (i % 2 == 0) ? 4'h2 : 4'h0;
      else if (i < 14) rb = 4'h2;
      else rb = 4'h0;
      step(1, rb, 4'h0);
      if (BTN_PRESS[1]) begin pcount++; pstep = i; end
      if (BTN_LEVEL[1] && !prev) rises++;
      prev = BTN_LEVEL[1];
    end
    chk("bounce_press_step", pstep, 9);
    chk("bounce_press_count", pcount, 1);
    chk("bounce_level_rises", rises, 1);

    // Short glitch on SW[2]: three cycles high is never accepted.
    acc = '0;
    for (int i = 0; i < 11; i++) begin
      step(1, 4'h0, (i < 3) ? 4'h4 : 4'h0);
      acc = acc | SW_LEVEL | SW_CHANGE;
    end
    chk("glitch_sw_activity", acc, 4'h0);

    // Long press on BTN[3], twice: one HOLD per press, 15 edges after PRESS.
    for (int rep = 0; rep < 2; rep++) begin
      pstep = -1; hstep = -1; rstep = -1; hcount = 0;
      for (int i = 0; i < 40; i++) begin
        step(1, (i < 30) ? 4'h8 : 4'h0, 4'h0);
        if (BTN_PRESS[3]) pstep = i;
        if (BTN_HOLD[3]) begin hcount++; hstep = i; end
        if (BTN_RELEASE[3]) rstep = i;
      end
      chk("long_press_step", pstep, 5);
      chk("long_hold_step", hstep, 20);
      chk("long_hold_count", hcount, 1);
      chk("long_release_step", rstep, 35);
    end

    // Everything rises together, then only the switches fall.
    for (int i = 0; i < 8; i++) begin
      step(1, 4'hF, 4'hF);
      if (i == 5) begin
        chk("simul_btn_press", BTN_PRESS, 4'hF);
        chk("simul_sw_change_rise", SW_CHANGE, 4'hF);
      end
    end
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      step(1, 4'hF, 4'h0);
      if (i == 5) chk("simul_sw_change_fall", SW_CHANGE, 4'hF);
      acc = acc | BTN_PRESS | BTN_RELEASE | BTN_HOLD;
    end
    chk("simul_btn_quiet", acc, 4'h0);
    for (int i = 0; i < 8; i++) step(1, 4'h0, 4'h0);

    // Random traffic with varying chatter rates and occasional resets.
    rb = '0; rs = '0; rate = 3;
    for (int t = 0; t < 3000; t++) begin
      if (t % 250 == 0) begin
        case ($urandom_range(2))
          0: rate = 3;
          1: rate = 10;
          default: rate = 40;
        endcase
      end
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(rate - 1) == 0) rb[c] = ~rb[c];
        if ($urandom_range(rate - 1) == 0) rs[c] = ~rs[c];
      end
      step(($urandom_range(499) != 0), rb, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_input_conditioner.md
Name: board_input_conditioner

Overview:
- Conditions the raw Arty S7 user inputs (BTN[3:0], SW[3:0]) before any MEST-Pro logic consumes them.
- Per channel: 2-flop synchronizer, stability-counter debounce, registered level output, single-cycle event pulses.
- Buttons also get a one-shot long-press pulse.
- Sits directly behind the board top-level pins, inside the mest_pro_top hierarchy. Every consumer of buttons and switches reads its outputs.

Parameters:
- N_BTN, 4, number of push-button channels
- N_SW, 4, number of slide-switch channels
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a new level (10 ms at 100 MHz); must be >=2
- HOLD_CYCLES, 100000000, cycles of accepted press before BTN_HOLD fires (1 s); must be >DEBOUNCE_CYCLES

Ports:
- CLK100MHZ  input  1  system clock, all logic on rising edge
- RSTN  input  1  synchronous active-low reset
- BTN  input  N_BTN  raw asynchronous buttons, 1 = pressed
- SW  input  N_SW  raw asynchronous switches
- BTN_LEVEL  output  N_BTN  debounced button level
- BTN_PRESS  output  N_BTN  1-cycle pulse on accepted 0->1
- BTN_RELEASE  output  N_BTN  1-cycle pulse on accepted 1->0
- BTN_HOLD  output  N_BTN  1-cycle pulse when a press has lasted HOLD_CYCLES
- SW_LEVEL  output  N_SW  debounced switch level
- SW_CHANGE  output  N_SW  1-cycle pulse on any accepted switch change

Behaviour:
- Reset, sampled with RSTN=0 on a clock edge:
  - Synchronizer flops, level regs, counters and all outputs go to 0.
  - Reset has priority over everything and aborts any count in progress.
- Synchronizer: 2 flops per channel, s1 <= raw, s2 <= s1. Raw inputs feed nothing else.
- Debounce, per channel:
  - cnt clears whenever s2 == level.
  - While s2 != level, cnt increments each edge.
  - On the edge where s2 != level and cnt == DEBOUNCE_CYCLES-1: level <= s2, cnt <= 0, and the matching event pulse is registered on that same edge.
- Latency: raw change first sampled at edge e0 -> level and pulse visible after edge e0+DEBOUNCE_CYCLES+1 (2 sync + D-1 count edges).
- Glitch rejection:
  - Any return of s2 to the current level before the count completes clears cnt.
  - No level change, no pulse.
  - Chatter restarts the window from zero.
- Pulses:
  - Exactly one cycle wide, registered.
  - PRESS and RELEASE for the same channel are never high together.
  - Pulses from different channels are independent and may coincide.
- Button hold:
  - hcnt clears while BTN_LEVEL=0.
  - While BTN_LEVEL=1, hcnt increments, saturating at HOLD_CYCLES-1.
  - BTN_HOLD fires for one cycle on the edge hcnt reaches HOLD_CYCLES-1.
  - No repeat until the channel is released (level 0) and pressed again.
  - A release before the hold threshold produces no BTN_HOLD.
- Switch channels use the identical debounce. SW_CHANGE = registered OR of the rise/fall pulses; there is no hold logic.
- Input already high at reset deassertion is treated as a new event: level rises with a PRESS/CHANGE pulse D+1 edges after the first post-reset sampling edge.
- Counter widths: $clog2(DEBOUNCE_CYCLES) and $clog2(HOLD_CYCLES). No wrap is possible because both counters clear or saturate.

Decomposition:
- Shared package mest_pro_pkg:
  - DEBOUNCE_CYCLES_DEFAULT (1000000), HOLD_CYCLES_DEFAULT (100000000)
  - Simulation overrides DEBOUNCE_CYCLES_SIM (4), HOLD_CYCLES_SIM (16)
  - N_BTN_BOARD, N_SW_BOARD
- One sub-module, debounce_channel:
  - Contains the synchronizer, debounce counter, level register, rise/fall pulses, and optional hold counter, enabled by parameter HOLD_EN.
  - Instantiated by generate loops: N_BTN with HOLD_EN=1, N_SW with HOLD_EN=0.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=16):
- Clean press: BTN[0] 0->1 before edge e0, held -> BTN_LEVEL[0]=1 and BTN_PRESS[0]=1 for exactly one cycle after edge e5; nothing else toggles.
- Bounce: BTN[1] toggles 1,0,1,0 on successive cycles, then holds 1 -> single BTN_PRESS[1] pulse, 5 edges after the last transition is sampled; BTN_LEVEL[1] never glitches.
- Short glitch: SW[2] high for 3 cycles then low -> SW_LEVEL and SW_CHANGE remain 0 throughout.
- Long press: BTN[3] held 30 cycles then released -> PRESS at e5, exactly one BTN_HOLD 15 edges after PRESS, RELEASE 5 edges after release is sampled; a second 30-cycle press gives one more HOLD.
- Reset mid-count: BTN[0] high, RSTN=0 at edge e3 for 2 cycles -> all outputs 0 during reset; after RSTN=1, PRESS fires 5 edges after the first post-reset sample.
- Simultaneous: all BTN and SW rise on the same cycle -> all 4 BTN_PRESS and 4 SW_CHANGE pulse on the same cycle; SW falls later -> SW_CHANGE pulses again, no BTN activity.
